can_bus_responder: RTL and testbench



---
 rtl/can_bus_pkg.sv | 24 ++
 rtl/can_reg_bank.sv | 55 +++++
 rtl/can_bus_responder.sv | 129 ++++++++++++
 tb/tb_can_bus_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/can_bus_pkg.sv
// Shared definitions for the CAN controller parallel-bus responder:
// FSM encodings matching the host master, strobe polarities and defaults.
package can_bus_pkg;

  typedef enum logic [7:0] {
    RSP_IDLE  = 8'h01,
    RSP_ADDR  = 8'h02,
    RSP_SEL   = 8'h04,
    RSP_WRITE = 8'h08,
    RSP_READ  = 8'h10,
    RSP_END   = 8'h20
  } rsp_state_e;

  localparam logic CS_ACTIVE     = 1'b0;
  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic ALE_ACTIVE    = 1'b1;

  localparam logic [7:0] OOR_RDATA_DEFAULT = 8'h00;

  function automatic logic addr_in_range(input logic [7:0] addr, input int depth);
    return int'(addr) < depth;
  endfunction

endpackage

// File: rtl/can_reg_bank.sv
// Byte register array with a bus write port (priority), a local write
// port, one asynchronous read port and a same-cycle collision flag.
module can_reg_bank #(
  parameter int REG_DEPTH = 32
) (
  input  logic                         sys_clk,
  input  logic                         sys_reset,
  input  logic                         bus_wr_en,
  input  logic [$clog2(REG_DEPTH)-1:0] bus_wr_idx,
  input  logic [7:0]                   bus_wr_data,
  input  logic                         usr_wr_en,
  input  logic [$clog2(REG_DEPTH)-1:0] usr_wr_idx,
  input  logic [7:0]                   usr_wr_data,
  input  logic [$clog2(REG_DEPTH)-1:0] rd_idx,
  output logic [7:0]                   rd_data,
  output logic                         usr_drop
);

  localparam int IDX_W = $clog2(REG_DEPTH);

  logic [7:0]           mem_q [REG_DEPTH];
  logic [7:0]           mem_d [REG_DEPTH];
  logic [REG_DEPTH-1:0] bus_hit;
  logic [REG_DEPTH-1:0] usr_hit;

  for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : g_hit
    assign bus_hit[gi] = bus_wr_en && (bus_wr_idx == IDX_W'(gi));
    assign usr_hit[gi] = usr_wr_en && (usr_wr_idx == IDX_W'(gi));
  end

  always_comb begin
    for (int i = 0; i < REG_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (bus_hit[i]) begin
        mem_d[i] = bus_wr_data;
      end else if (usr_hit[i]) begin
        mem_d[i] = usr_wr_data;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < REG_DEPTH; i++) begin
      if (sys_reset) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data  = mem_q[rd_idx];
  assign usr_drop = bus_wr_en && usr_wr_en && (bus_wr_idx == usr_wr_idx);

endmodule

// File: rtl/can_bus_responder.sv
// Peripheral end of the multiplexed ALE/CS/RD/WR/AD CAN controller bus:
// latches addresses, commits writes to a local register bank, drives reads.
module can_bus_responder
  import can_bus_pkg::*;
#(
  parameter int         REG_DEPTH = 32,
  parameter logic [7:0] OOR_RDATA = OOR_RDATA_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       can_ale,
  input  logic       can_cs,
  input  logic       can_rd,
  input  logic       can_wr,
  inout  wire  [7:0] can_ad,
  input  logic       i_usr_wr_en,
  input  logic [7:0] i_usr_wr_addr,
  input  logic [7:0] i_usr_wr_data,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_wr_valid,
  output logic       o_rd_strobe,
  output logic       o_usr_wr_drop,
  output logic       o_proto_err
);

  localparam int IDX_W = $clog2(REG_DEPTH);

  rsp_state_e state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       rd_q, wr_q;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_valid_q, rd_strobe_q, usr_drop_q, proto_err_q;

  logic       proto_err, wr_commit, rd_done;
  logic       addr_ok, usr_addr_ok, bank_drop, drive_ad;
  logic [7:0] bank_rdata, rdata;

  assign addr_ok     = addr_in_range(addr_q, REG_DEPTH);
  assign usr_addr_ok = addr_in_range(i_usr_wr_addr, REG_DEPTH);

  always_comb begin
    proto_err = ((can_rd == STROBE_ACTIVE) && (can_wr == STROBE_ACTIVE))
             || ((can_ale == ALE_ACTIVE) && (can_cs == CS_ACTIVE))
             || ((can_cs != CS_ACTIVE) && (state_q inside {RSP_SEL, RSP_WRITE, RSP_READ}));
    wr_commit = !proto_err && (state_q == RSP_WRITE) && (wr_q == STROBE_ACTIVE)
             && (can_wr != STROBE_ACTIVE) && (can_cs == CS_ACTIVE);
    rd_done   = !proto_err && (state_q == RSP_READ) && (rd_q == STROBE_ACTIVE)
             && (can_rd != STROBE_ACTIVE);

    state_d = state_q;
    if (proto_err) begin
      state_d = RSP_IDLE;
    end else begin
      case (state_q)
        RSP_IDLE:  if (can_ale == ALE_ACTIVE) state_d = RSP_ADDR;
        RSP_ADDR:  if (can_ale != ALE_ACTIVE)
                     state_d = (can_cs == CS_ACTIVE) ? RSP_SEL : RSP_IDLE;
        RSP_SEL:   if (can_wr == STROBE_ACTIVE) state_d = RSP_WRITE;
                   else if (can_rd == STROBE_ACTIVE) state_d = RSP_READ;
        RSP_WRITE: if (can_wr != STROBE_ACTIVE) state_d = RSP_END;
        RSP_READ:  if (can_rd != STROBE_ACTIVE) state_d = RSP_END;
        RSP_END:   if (can_cs != CS_ACTIVE) state_d = RSP_IDLE;
        default:   state_d = RSP_IDLE;
      endcase
    end

    // Address is only latched while the chip is deselected.
    addr_d    = ((can_ale == ALE_ACTIVE) && (can_cs != CS_ACTIVE)) ? can_ad : addr_q;
    wr_addr_d = wr_commit ? addr_q : wr_addr_q;
    wr_data_d = wr_commit ? can_ad : wr_data_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q     <= RSP_IDLE;
      addr_q      <= '0;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      rd_strobe_q <= 1'b0;
      usr_drop_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_q        <= can_rd;
      wr_q        <= can_wr;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_commit;
      rd_strobe_q <= rd_done;
      usr_drop_q  <= bank_drop;
      proto_err_q <= proto_err;
    end
  end

  can_reg_bank #(
    .REG_DEPTH (REG_DEPTH)
  ) u_bank (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .bus_wr_en   (wr_commit && addr_ok),
    .bus_wr_idx  (addr_q[IDX_W-1:0]),
    .bus_wr_data (can_ad),
    .usr_wr_en   (i_usr_wr_en && usr_addr_ok),
    .usr_wr_idx  (i_usr_wr_addr[IDX_W-1:0]),
    .usr_wr_data (i_usr_wr_data),
    .rd_idx      (addr_q[IDX_W-1:0]),
    .rd_data     (bank_rdata),
    .usr_drop    (bank_drop)
  );

  // Read data follows the raw strobes so it is valid within the RD-low cycle.
  assign rdata    = addr_ok ? bank_rdata : OOR_RDATA;
  assign drive_ad = !sys_reset && (can_cs == CS_ACTIVE) && (can_rd == STROBE_ACTIVE);
  assign can_ad   = drive_ad ? rdata : 8'hzz;

  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_wr_valid    = wr_valid_q;
  assign o_rd_strobe   = rd_strobe_q;
  assign o_usr_wr_drop = usr_drop_q;
  assign o_proto_err   = proto_err_q;

endmodule

// File: tb/tb_can_bus_responder.sv
// Scoreboard bench for can_bus_responder: a bus-master driver feeds a plain
// register-array model; a monitor pops expected events as the DUT emits them.
`timescale 1ns/1ps
module tb_can_bus_responder;

  localparam int DEPTH = 32;

  logic       sys_clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       can_ale = 1'b0, can_cs = 1'b1, can_rd = 1'b1, can_wr = 1'b1;
  logic [7:0] m_ad = 8'h00;
  logic       m_ad_en = 1'b0;
  wire  [7:0] can_ad;
  logic       i_usr_wr_en = 1'b0;
  logic [7:0] i_usr_wr_addr = 8'h00, i_usr_wr_data = 8'h00;
  logic [7:0] o_wr_addr, o_wr_data;
  logic       o_wr_valid, o_rd_strobe, o_usr_wr_drop, o_proto_err;

  assign can_ad = m_ad_en ? m_ad : 8'hzz;
  always #100 sys_clk = ~sys_clk;

  can_bus_responder #(.REG_DEPTH(DEPTH), .OOR_RDATA(8'h00)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .can_ale(can_ale), .can_cs(can_cs), .can_rd(can_rd), .can_wr(can_wr),
    .can_ad(can_ad),
    .i_usr_wr_en(i_usr_wr_en), .i_usr_wr_addr(i_usr_wr_addr), .i_usr_wr_data(i_usr_wr_data),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_valid(o_wr_valid),
    .o_rd_strobe(o_rd_strobe), .o_usr_wr_drop(o_usr_wr_drop), .o_proto_err(o_proto_err)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  model [DEPTH];
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  bit          exp_err_q [$];
  bit          exp_drop_q [$];
  logic [7:0]  cap_rd = 8'h00;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (can_cs == 1'b0 && can_rd == 1'b0) cap_rd = can_ad;
      if (m_ad_en) check("bus_release", {8'h00, can_ad}, {8'h00, m_ad});
      if (o_wr_valid) begin
        if (exp_wr_q.size() == 0) check("wr_valid_unexpected", {15'd0, o_wr_valid}, 16'd0);
        else begin
          check("wr_addr_data", {o_wr_addr, o_wr_data}, exp_wr_q[0]);
          void'(exp_wr_q.pop_front());
        end
      end
      if (o_rd_strobe) begin
        if (exp_rd_q.size() == 0) check("rd_strobe_unexpected", {15'd0, o_rd_strobe}, 16'd0);
        else begin
          check("rd_data", {8'h00, cap_rd}, {8'h00, exp_rd_q[0]});
          void'(exp_rd_q.pop_front());
        end
      end
      if (o_proto_err) begin
        if (exp_err_q.size() == 0) check("proto_err_unexpected", {15'd0, o_proto_err}, 16'd0);
        else begin
          check("proto_err", {15'd0, o_proto_err}, {15'd0, exp_err_q[0]});
          void'(exp_err_q.pop_front());
        end
      end
      if (o_usr_wr_drop) begin
        if (exp_drop_q.size() == 0) check("drop_unexpected", {15'd0, o_usr_wr_drop}, 16'd0);
        else begin
          check("usr_drop", {15'd0, o_usr_wr_drop}, {15'd0, exp_drop_q[0]});
          void'(exp_drop_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic addr_phase(input logic [7:0] a);
    step(); can_ale = 1'b1; can_cs = 1'b1; m_ad_en = 1'b1; m_ad = a;
    step();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d,
                           input bit ue, input logic [7:0] ua, input logic [7:0] ud);
    addr_phase(a);
    step(); can_ale = 1'b0; can_cs = 1'b0; m_ad = d;
    step(); can_wr = 1'b0;
    step(); can_wr = 1'b1; i_usr_wr_en = ue; i_usr_wr_addr = ua; i_usr_wr_data = ud;
    step(); i_usr_wr_en = 1'b0; can_cs = 1'b1; m_ad_en = 1'b0;
    exp_wr_q.push_back({a, d});
    if (ue && ua < DEPTH) begin
      if (ua == a) exp_drop_q.push_back(1'b1);
      else model[ua] = ud;
    end
    if (a < DEPTH) model[a] = d;
    $display("write addr=%h data=%h usr_en=%0d usr_addr=%h usr_data=%h", a, d, ue, ua, ud);
  endtask

  task automatic bus_read(input logic [7:0] a);
    logic [7:0] e;
    addr_phase(a);
    step(); can_ale = 1'b0; can_cs = 1'b0; m_ad_en = 1'b0;
    step(); can_rd = 1'b0;
    step(); can_rd = 1'b1;
    step(); can_cs = 1'b1;
    e = (a < DEPTH) ? model[a] : 8'h00;
    exp_rd_q.push_back(e);
    $display("read  addr=%h expect=%h", a, e);
  endtask

  task automatic usr_write(input logic [7:0] a, input logic [7:0] d);
    step(); i_usr_wr_en = 1'b1; i_usr_wr_addr = a; i_usr_wr_data = d;
    step(); i_usr_wr_en = 1'b0;
    if (a < DEPTH) model[a] = d;
    $display("local addr=%h data=%h", a, d);
  endtask

  task automatic err_rd_wr(input logic [7:0] a);
    addr_phase(a);
    step(); can_ale = 1'b0; can_cs = 1'b0; m_ad_en = 1'b0;
    step(); can_rd = 1'b0; can_wr = 1'b0;
    step(); can_rd = 1'b1; can_wr = 1'b1; can_cs = 1'b1;
    exp_err_q.push_back(1'b1);
    $display("error rd+wr low addr=%h", a);
  endtask

  task automatic err_cs_abort(input logic [7:0] a, input logic [7:0] d);
    addr_phase(a);
    step(); can_ale = 1'b0; can_cs = 1'b0; m_ad = d;
    step(); can_wr = 1'b0;
    step(); can_cs = 1'b1;
    step(); can_wr = 1'b1; m_ad_en = 1'b0;
    exp_err_q.push_back(1'b1);
    $display("error cs abort in write addr=%h", a);
  endtask

  task automatic err_ale_cs(input logic [7:0] a);
    step(); can_ale = 1'b1; can_cs = 1'b0; m_ad_en = 1'b1; m_ad = a;
    step(); can_ale = 1'b0; can_cs = 1'b1; m_ad_en = 1'b0;
    exp_err_q.push_back(1'b1);
    $display("error ale with cs low");
  endtask

  initial begin
    logic [7:0] a, d, ua;
    int op;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

    repeat (3) step();
    sys_reset = 1'b0;
    step();
    check("rst_wr_addr", {8'h00, o_wr_addr}, 16'h0000);
    check("rst_wr_data", {8'h00, o_wr_data}, 16'h0000);
    check("rst_pulses", {12'd0, o_wr_valid, o_rd_strobe, o_usr_wr_drop, o_proto_err}, 16'h0000);
    bus_read(8'h00);
    bus_read(8'h1F);

    bus_write(8'h03, 8'h12, 1'b0, 8'h00, 8'h00);
    bus_read(8'h03);
    bus_write(8'h00, 8'h5A, 1'b0, 8'h00, 8'h00);
    bus_write(8'h40, 8'hAA, 1'b0, 8'h00, 8'h00);
    bus_read(8'h40);
    bus_read(8'h00);

    bus_write(8'h05, 8'h77, 1'b1, 8'h05, 8'h55);
    bus_read(8'h05);
    bus_write(8'h05, 8'h78, 1'b1, 8'h06, 8'h66);
    bus_read(8'h05);
    bus_read(8'h06);

    err_rd_wr(8'h03);
    bus_read(8'h03);
    err_cs_abort(8'h03, 8'hEE);
    bus_read(8'h03);
    err_ale_cs(8'h07);
    bus_read(8'h07);

    bus_write(8'h03, 8'h12, 1'b0, 8'h00, 8'h00);
    addr_phase(8'h03);
    step(); can_ale = 1'b0; can_cs = 1'b0; m_ad = 8'h99;
    step(); can_wr = 1'b0;
    step(); sys_reset = 1'b1;
    step(); sys_reset = 1'b0; can_wr = 1'b1; can_cs = 1'b1; m_ad_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    $display("reset during write");
    step();
    check("post_rst_wr_addr", {8'h00, o_wr_addr}, 16'h0000);
    check("post_rst_wr_data", {8'h00, o_wr_data}, 16'h0000);
    bus_read(8'h03);
    bus_write(8'h03, 8'h34, 1'b0, 8'h00, 8'h00);
    bus_read(8'h03);

    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, DEPTH - 1));
      d  = 8'($urandom_range(0, 255));
      ua = ($urandom_range(0, 1) == 0) ? a : 8'($urandom_range(0, DEPTH - 1));
      case (op)
        0, 1, 2: bus_write(a, d, 1'b0, 8'h00, 8'h00);
        3, 4, 5: bus_read(a);
        6:       usr_write(ua, d);
        7:       bus_write(a, d, 1'b1, ua, 8'($urandom_range(0, 255)));
        8:       err_rd_wr(a);
        default: err_cs_abort(a, d);
      endcase
    end
    for (int i = 0; i < DEPTH; i++) bus_read(8'(i));

    repeat (4) step();
    check("wr_queue_empty", 16'(exp_wr_q.size()), 16'd0);
    check("rd_queue_empty", 16'(exp_rd_q.size()), 16'd0);
    check("err_queue_empty", 16'(exp_err_q.size()), 16'd0);
    check("drop_queue_empty", 16'(exp_drop_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
